// File: rtl/memory_stage_if.sv
// Data-memory port of the MEM stage: req/ack handshake with doubleword-aligned address,
// lane-shifted write data, byte enables and aligned read data.
interface memory_stage_if;
   logic        dmem_req;
   logic        dmem_we;
   logic [63:0] dmem_addr;
   logic [63:0] dmem_wdata;
   logic [7:0]  dmem_be;
   logic        dmem_ack;
   logic [63:0] dmem_rdata;

   modport master (
      output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      input  dmem_ack, dmem_rdata
   );

   modport slave (
      input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
      output dmem_ack, dmem_rdata
   );
endinterface

// File: rtl/memory_stage.sv
// RV64 MEM stage: issues loads/stores over a req/ack port, stalls EX while waiting, registers MEM/WB.
// Optional macro MEM_MISALIGN_CHECK_EN: reject misaligned accesses and raise sticky misalign_err.
module memory_stage #(
   parameter int unsigned ACK_TIMEOUT = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  EXMEM_ready,
   input  logic [63:0]           exmm_aluresult,
   input  logic [63:0]           EXMEM_rs2,
   input  logic [5:0]            dest_reg,
   input  logic                  mem_active,
   input  logic                  load,
   input  logic                  ld_unsigned,
   input  logic [7:0]            ldst_size,
   input  logic                  EXMEM_wbactive,
   input  logic                  EXMEM_ecall,
   output logic                  MEMEX_stall,
   output logic [5:0]            MEMEX_rd,
   output logic [63:0]           MEMEX_rdval,
   output logic                  MEMEX_wbactive,
   output logic                  MEMWB_ready,
   output logic [5:0]            MEMWB_rd,
   output logic [63:0]           MEMWB_rdval,
   output logic                  MEMWB_wbactive,
   output logic                  MEMWB_ecall,
   output logic                  bus_err,
   memory_stage_if.master        dmem
`ifdef MEM_MISALIGN_CHECK_EN
   ,output logic                 misalign_err
`endif
);

   typedef enum logic {IDLE, WAIT} state_e;

   localparam logic [15:0] TO_LAST = 16'(ACK_TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [7:0]  be_q, be_d;
   logic [2:0]  off_q, off_d;
   logic [1:0]  lg_q, lg_d;
   logic        uns_q, uns_d;
   logic        load_q, load_d;
   logic [5:0]  rd_q, rd_d;
   logic        wb_q, wb_d;
   logic        wbrdy_q, wbrdy_d;
   logic [5:0]  wbrd_q, wbrd_d;
   logic [63:0] wbval_q, wbval_d;
   logic        wbact_q, wbact_d;
   logic        wbecall_q, wbecall_d;
   logic        berr_q, berr_d;
`ifdef MEM_MISALIGN_CHECK_EN
   logic        merr_q, merr_d;
`endif

   // Request decode: log2 size, byte mask and the offset bits that must be zero
   logic [1:0]  in_lg;
   logic [7:0]  in_base;
   logic [2:0]  in_amask;
   logic [2:0]  off_raw, off_al;
   logic [7:0]  be_new;
   logic [63:0] wdata_new;
   logic        bad_align;
   logic [63:0] rd_shift;
   logic [63:0] ld_val;

   always_comb begin
      case (ldst_size)
         8'd8:    begin in_lg = 2'd0; in_base = 8'h01; in_amask = 3'b111; end
         8'd16:   begin in_lg = 2'd1; in_base = 8'h03; in_amask = 3'b110; end
         8'd32:   begin in_lg = 2'd2; in_base = 8'h0F; in_amask = 3'b100; end
         default: begin in_lg = 2'd3; in_base = 8'hFF; in_amask = 3'b000; end
      endcase
   end

   assign off_raw   = exmm_aluresult[2:0];
   assign off_al    = off_raw & in_amask;
   assign be_new    = in_base << off_al;
   assign wdata_new = EXMEM_rs2 << {off_al, 3'b000};
`ifdef MEM_MISALIGN_CHECK_EN
   assign bad_align = (off_raw & ~in_amask) != 3'b000;
`else
   assign bad_align = 1'b0;
`endif

   assign rd_shift = dmem.dmem_rdata >> {off_q, 3'b000};

   always_comb begin
      case (lg_q)
         2'd0:    ld_val = uns_q ? {56'd0, rd_shift[7:0]}  : {{56{rd_shift[7]}},  rd_shift[7:0]};
         2'd1:    ld_val = uns_q ? {48'd0, rd_shift[15:0]} : {{48{rd_shift[15]}}, rd_shift[15:0]};
         2'd2:    ld_val = uns_q ? {32'd0, rd_shift[31:0]} : {{32{rd_shift[31]}}, rd_shift[31:0]};
         default: ld_val = rd_shift;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      be_d      = be_q;
      off_d     = off_q;
      lg_d      = lg_q;
      uns_d     = uns_q;
      load_d    = load_q;
      rd_d      = rd_q;
      wb_d      = wb_q;
      wbrdy_d   = 1'b0;
      wbrd_d    = wbrd_q;
      wbval_d   = wbval_q;
      wbact_d   = wbact_q;
      wbecall_d = wbecall_q;
      berr_d    = berr_q;
`ifdef MEM_MISALIGN_CHECK_EN
      merr_d    = merr_q;
`endif
      case (state_q)
         IDLE: begin
            if (EXMEM_ready) begin
               if (!mem_active) begin
                  wbrdy_d   = 1'b1;
                  wbrd_d    = dest_reg;
                  wbval_d   = exmm_aluresult;
                  wbact_d   = EXMEM_wbactive;
                  wbecall_d = EXMEM_ecall;
               end else if (bad_align) begin
                  wbrdy_d   = 1'b1;
                  wbrd_d    = dest_reg;
                  wbval_d   = '0;
                  wbact_d   = 1'b0;
                  wbecall_d = 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
                  merr_d    = 1'b1;
`endif
               end else begin
                  state_d = WAIT;
                  cnt_d   = '0;
                  req_d   = 1'b1;
                  we_d    = !load;
                  addr_d  = {exmm_aluresult[63:3], 3'b000};
                  wdata_d = load ? '0 : wdata_new;
                  be_d    = be_new;
                  off_d   = off_al;
                  lg_d    = in_lg;
                  uns_d   = ld_unsigned;
                  load_d  = load;
                  rd_d    = dest_reg;
                  wb_d    = EXMEM_wbactive;
               end
            end
         end
         WAIT: begin
            if (dmem.dmem_ack) begin
               state_d   = IDLE;
               req_d     = 1'b0;
               wbrdy_d   = 1'b1;
               wbrd_d    = rd_q;
               wbval_d   = load_q ? ld_val : '0;
               wbact_d   = load_q && wb_q;
               wbecall_d = 1'b0;
            end else if (ACK_TIMEOUT != 0 && cnt_q == TO_LAST) begin
               state_d   = IDLE;
               req_d     = 1'b0;
               berr_d    = 1'b1;
               wbrdy_d   = 1'b1;
               wbrd_d    = rd_q;
               wbval_d   = '0;
               wbact_d   = 1'b0;
               wbecall_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         be_q      <= '0;
         off_q     <= '0;
         lg_q      <= '0;
         uns_q     <= 1'b0;
         load_q    <= 1'b0;
         rd_q      <= '0;
         wb_q      <= 1'b0;
         wbrdy_q   <= 1'b0;
         wbrd_q    <= '0;
         wbval_q   <= '0;
         wbact_q   <= 1'b0;
         wbecall_q <= 1'b0;
         berr_q    <= 1'b0;
`ifdef MEM_MISALIGN_CHECK_EN
         merr_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         be_q      <= be_d;
         off_q     <= off_d;
         lg_q      <= lg_d;
         uns_q     <= uns_d;
         load_q    <= load_d;
         rd_q      <= rd_d;
         wb_q      <= wb_d;
         wbrdy_q   <= wbrdy_d;
         wbrd_q    <= wbrd_d;
         wbval_q   <= wbval_d;
         wbact_q   <= wbact_d;
         wbecall_q <= wbecall_d;
         berr_q    <= berr_d;
`ifdef MEM_MISALIGN_CHECK_EN
         merr_q    <= merr_d;
`endif
      end
   end

   assign MEMEX_stall     = (state_q == WAIT);
   assign MEMWB_ready     = wbrdy_q;
   assign MEMWB_rd        = wbrd_q;
   assign MEMWB_rdval     = wbval_q;
   assign MEMWB_wbactive  = wbact_q;
   assign MEMWB_ecall     = wbecall_q;
   assign MEMEX_rd        = wbrd_q;
   assign MEMEX_rdval     = wbval_q;
   assign MEMEX_wbactive  = wbact_q;
   assign bus_err         = berr_q;
   assign dmem.dmem_req   = req_q;
   assign dmem.dmem_we    = we_q;
   assign dmem.dmem_addr  = addr_q;
   assign dmem.dmem_wdata = wdata_q;
   assign dmem.dmem_be    = be_q;
`ifdef MEM_MISALIGN_CHECK_EN
   assign misalign_err    = merr_q;
`endif

endmodule

// File: doc/memory_stage.md
# memory_stage

Pipeline MEM stage of the RV64 core; the consumer of the execute stage's EX→MEM bundle and the producer of the MEM→EX forwarding/stall signals. Issues loads and stores to the data-memory port with a req/ack handshake, aligns store data and byte enables, extracts and extends load data, and registers the retiring instruction into the MEM/WB bundle. It stalls execute while an access is outstanding.

## Interface
- ACK_TIMEOUT, 0, max cycles in WAIT before abort; 0 = never time out; 16-bit counter
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- EXMEM_ready  in  1  EX bundle valid this cycle
- exmm_aluresult  in  64  ALU result / effective address
- EXMEM_rs2  in  64  store data
- dest_reg  in  6  destination register
- mem_active  in  1  instruction is load or store
- load  in  1  1 = load, 0 = store (when mem_active)
- ld_unsigned  in  1  zero-extend load (lbu/lhu/lwu)
- ldst_size  in  8  access bits: 8/16/32/64; other values treated as 64
- EXMEM_wbactive  in  1  instruction writes rd
- EXMEM_ecall  in  1  ecall marker
- MEMEX_stall  out  1  hold execute stage
- MEMEX_rd, MEMEX_rdval, MEMEX_wbactive  out  6/64/1  forwarding; equal to MEMWB_rd/rdval/wbactive
- MEMWB_ready, MEMWB_rd, MEMWB_rdval, MEMWB_wbactive, MEMWB_ecall  out  1/6/64/1/1  registered bundle to WB
- dmem_req, dmem_we  out  1/1  request, write enable
- dmem_addr  out  64  doubleword address (addr[2:0] forced 0)
- dmem_wdata, dmem_be  out  64/8  lane-shifted store data, byte enables
- dmem_ack, dmem_rdata  in  1/64  completion, aligned doubleword read data
- bus_err  out  1  sticky: access timed out

## Operation
- States: IDLE, WAIT. MEMEX_stall = (state == WAIT).
- Accept: edge with state IDLE and EXMEM_ready=1.
  - Non-memory op: MEMWB_* ← {1, dest_reg, exmm_aluresult, EXMEM_wbactive, EXMEM_ecall}.
  - Memory op: latch addr, size, load, ld_unsigned, dest_reg, wbactive; dmem_req←1; state→WAIT; MEMWB_ready←0.
- EXMEM_ready=0 in IDLE: MEMWB_ready←0, other MEMWB fields hold.
- off = addr[2:0]; nbytes = size/8. Store: dmem_wdata = rs2 << 8·off; dmem_be = ((1<<nbytes)−1) << off. Load: dmem_be likewise, dmem_we=0.
- WAIT: request fields stable, dmem_req=1. On dmem_ack: dmem_req←0, state→IDLE, MEMWB_ready←1, MEMWB_rd←latched rd; load: rdval ← (rdata >> 8·off) truncated to nbytes, sign- or zero-extended per ld_unsigned (64-bit ignores it), wbactive←latched; store: rdval←0, wbactive←0. EX inputs are not accepted on the ack edge.
- Timeout (ACK_TIMEOUT≠0): counter reaches ACK_TIMEOUT with no ack → dmem_req←0, IDLE, bus_err←1, MEMWB_ready←1, wbactive←0, rdval←0.
- dmem_ack while dmem_req=0 ignored.

## Timing
- Reset: state IDLE; all outputs 0 (stall, req, we, addr, wdata, be, MEMWB_*, MEMEX_*, bus_err); counter 0.
- Non-memory op: MEMWB valid 1 cycle after accept edge; no stall.
- Memory op accepted edge N: req high from cycle N+1; ack at edge M ≥ N+1 → MEMWB valid after M; stall high cycles N+1..M. Zero-wait ack = 1 stall cycle.
- Reset mid-WAIT: req low next cycle; in-flight access abandoned, pending ack ignored; bus_err cleared only by reset.

## Configuration
- MEM_MISALIGN_CHECK_EN defined: off not multiple of nbytes → no request issued; retires next edge as MEMWB_ready=1, wbactive=0, rdval=0; sticky misalign_err output (1 bit, reset 0) set.
- Undefined: port misalign_err absent; off low bits masked to natural alignment (off & ~(nbytes−1)) before shifting/byte-enables.

## Test plan
- addi result 0x2A, rd=5, wbactive=1 → next cycle MEMWB_ready=1, rd=5, rdval=0x2A, MEMEX_stall never high.
- lb addr 0x1003, rdata 0x00000000_80000000 (byte3=0x80), ack after 3 req cycles → stall 3 cycles, rdval 0xFFFFFFFF_FFFFFF80; same with ld_unsigned=1 → 0x80.
- sh addr 0x2006, rs2 0xBEEF, ack immediately → dmem_we=1, be=0xC0, wdata=0xBEEF0000_00000000, MEMWB wbactive=0, 1 stall cycle.
- ACK_TIMEOUT=4, ld with no ack → req drops after 4 WAIT cycles, bus_err=1, MEMWB_ready=1 wbactive=0; later ack ignored.
- reset asserted in WAIT → all outputs 0 next cycle; stray ack in IDLE produces no MEMWB_ready.
- MEM_MISALIGN_CHECK_EN: lw addr 0x1002 → no dmem_req, misalign_err=1; undefined: access issued at lane 0, be=0x0F.
